// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: control codes, opcodes,
// the operand/control bundle held in each buffer entry, and FSM states.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // RV32 major opcodes handled by this stage
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One buffer entry: 32 + 32 + 4 + 1 = 69 bits
  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [3:0]      ctrl;
    logic            illegal;
  } alu_bundle_t;

  // Value held by both entries out of reset
  localparam alu_bundle_t BUNDLE_RESET = '{in1: '0, in2: '0, ctrl: 4'b0000, illegal: 1'b0};

  // Unsupported encodings still travel through the buffer, with zeroed operands
  localparam alu_bundle_t BUNDLE_ILLEGAL = '{in1: '0, in2: '0, ctrl: ALU_ADD, illegal: 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } issue_state_t;

  // Build a legal entry from a control code and ordered operands
  function automatic alu_bundle_t make_bundle(input logic [3:0] ctrl,
                                              input logic [XLEN-1:0] in1,
                                              input logic [XLEN-1:0] in2);
    alu_bundle_t b;
    b.in1     = in1;
    b.in2     = in2;
    b.ctrl    = ctrl;
    b.illegal = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of instruction fields into ALU control plus ordered
// operands. Subtract forms swap the operands because the ALU computes
// in2 + ~in1 + 1, so in1=rs2, in2=rs1 gives rs1 - rs2.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output alu_bundle_t     bundle
);

  // Opcode/funct table lookup; anything not matched is flagged illegal
  always_comb begin
    bundle = BUNDLE_ILLEGAL;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: bundle = funct7_5 ? make_bundle(ALU_SUB, rs2_data, rs1_data)
                                    : make_bundle(ALU_ADD, rs1_data, rs2_data);
          3'b111: bundle = make_bundle(ALU_AND, rs1_data, rs2_data);
          3'b110: bundle = make_bundle(ALU_OR,  rs1_data, rs2_data);
          default: bundle = BUNDLE_ILLEGAL;
        endcase
      end
      OP_I: begin
        case (funct3)
          3'b000: bundle = make_bundle(ALU_ADD, rs1_data, imm);
          3'b111: bundle = make_bundle(ALU_AND, rs1_data, imm);
          3'b110: bundle = make_bundle(ALU_OR,  rs1_data, imm);
          default: bundle = BUNDLE_ILLEGAL;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == 3'b010) bundle = make_bundle(ALU_ADD, rs1_data, imm);
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001)
          bundle = make_bundle(ALU_SUB, rs2_data, rs1_data);
      end
      default: bundle = BUNDLE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue block: decodes into an ALU bundle and registers it
// through a two-entry (main + skid) buffer. Ready is a flop that only
// depends on buffer occupancy, so downstream ready never reaches decode
// combinationally.
module alu_issue
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7_5,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_in1,
  output logic [XLEN-1:0] o_alu_in2,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_illegal
);

  issue_state_t state_reg;
  alu_bundle_t  main_reg;
  alu_bundle_t  skid_reg;
  alu_bundle_t  dec_bundle;
  logic         valid_reg;
  logic         ready_reg;
  logic         accept;
  logic         consume;

  alu_ctrl_dec u_dec (
    .opcode   (i_opcode),
    .funct3   (i_funct3),
    .funct7_5 (i_funct7_5),
    .rs1_data (i_rs1_data),
    .rs2_data (i_rs2_data),
    .imm      (i_imm),
    .bundle   (dec_bundle)
  );

  // Handshakes are qualified only by registered flags
  assign accept  = i_valid && ready_reg;
  assign consume = valid_reg && i_ready;

  // Buffer state machine; valid/ready are registered alongside the state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_EMPTY;
      main_reg  <= BUNDLE_RESET;
      skid_reg  <= BUNDLE_RESET;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else if (i_flush) begin
      // Flush drops held entries and any input handshaking this cycle
      state_reg <= ST_EMPTY;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_reg  <= dec_bundle;
            state_reg <= ST_FULL;
            valid_reg <= 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && !consume) begin
            skid_reg  <= dec_bundle;
            state_reg <= ST_SKID;
            ready_reg <= 1'b0;
          end else if (accept && consume) begin
            main_reg  <= dec_bundle;
          end else if (consume) begin
            state_reg <= ST_EMPTY;
            valid_reg <= 1'b0;
          end
        end
        ST_SKID: begin
          // o_ready is low here, so only a consume can happen
          if (consume) begin
            main_reg  <= skid_reg;
            state_reg <= ST_FULL;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready    = ready_reg;
  assign o_valid    = valid_reg;
  assign o_alu_in1  = main_reg.in1;
  assign o_alu_in2  = main_reg.in2;
  assign o_alu_ctrl = main_reg.ctrl;
  assign o_illegal  = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a 2-deep FIFO model with a table decoder checked
// every cycle, plus directed vectors with literal expectations.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_funct7_5 = 1'b0;
  logic [31:0] i_rs1_data = '0;
  logic [31:0] i_rs2_data = '0;
  logic [31:0] i_imm = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_alu_in1;
  logic [31:0] o_alu_in2;
  logic [3:0]  o_alu_ctrl;
  logic        o_illegal;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011;

  typedef struct {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  ctrl;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   m_acc, m_con;

  alu_issue dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_funct7_5 (i_funct7_5),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_imm      (i_imm),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_alu_in1  (o_alu_in1),
    .o_alu_in2  (o_alu_in2),
    .o_alu_ctrl (o_alu_ctrl),
    .o_illegal  (o_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Instruction table from the decode rules
  function automatic exp_t model_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    exp_t e;
    e = '{in1: 32'd0, in2: 32'd0, ctrl: 4'b0010, illegal: 1'b1};
    if      (op == R && f3 == 3'd0 && !f7) e = '{a,  b,  4'b0010, 1'b0};
    else if (op == R && f3 == 3'd0 &&  f7) e = '{b,  a,  4'b0110, 1'b0};
    else if (op == R && f3 == 3'd7)        e = '{a,  b,  4'b0000, 1'b0};
    else if (op == R && f3 == 3'd6)        e = '{a,  b,  4'b0001, 1'b0};
    else if (op == I && f3 == 3'd0)        e = '{a,  im, 4'b0010, 1'b0};
    else if (op == I && f3 == 3'd7)        e = '{a,  im, 4'b0000, 1'b0};
    else if (op == I && f3 == 3'd6)        e = '{a,  im, 4'b0001, 1'b0};
    else if ((op == LD || op == ST) && f3 == 3'd2) e = '{a, im, 4'b0010, 1'b0};
    else if (op == BR && (f3 == 3'd0 || f3 == 3'd1)) e = '{b, a, 4'b0110, 1'b0};
    return e;
  endfunction

  // Reference ALU driven by the issued operands
  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return y + ~x + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // FIFO model: capacity two, ready means room, valid means non-empty
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_acc = i_valid && (q.size() < 2);
      m_con = (q.size() > 0) && i_ready;
      if (i_flush) begin
        q.delete();
      end else begin
        if (m_con) void'(q.pop_front());
        if (m_acc) q.push_back(model_dec(i_opcode, i_funct3, i_funct7_5, i_rs1_data, i_rs2_data, i_imm));
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 1);
      check("rst_in1", o_alu_in1, 0);
      check("rst_in2", o_alu_in2, 0);
      check("rst_ctrl", o_alu_ctrl, 0);
      check("rst_illegal", o_illegal, 0);
    end else begin
      check("ready", o_ready, q.size() < 2);
      check("valid", o_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("in1", o_alu_in1, q[0].in1);
        check("in2", o_alu_in2, q[0].in2);
        check("ctrl", o_alu_ctrl, q[0].ctrl);
        check("illegal", o_illegal, q[0].illegal);
      end
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    i_valid    = 1'b1;
    i_opcode   = op;
    i_funct3   = f3;
    i_funct7_5 = f7;
    i_rs1_data = a;
    i_rs2_data = b;
    i_imm      = im;
  endtask

  logic [6:0] ops [6] = '{R, I, LD, ST, BR, 7'b1101111};

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // ADD / SUB / BEQ with literal ALU results
    i_ready = 1'b1;
    drive(R, 3'd0, 1'b0, 32'd5, 32'd9, 32'd0);
    @(negedge clk);
    check("add_valid", o_valid, 1);
    check("add_ctrl", o_alu_ctrl, 4'b0010);
    check("add_in1", o_alu_in1, 5);
    check("add_in2", o_alu_in2, 9);
    check("add_res", alu(o_alu_ctrl, o_alu_in1, o_alu_in2), 14);
    drive(R, 3'd0, 1'b1, 32'd7, 32'd3, 32'd0);
    @(negedge clk);
    check("sub_ctrl", o_alu_ctrl, 4'b0110);
    check("sub_in1", o_alu_in1, 3);
    check("sub_in2", o_alu_in2, 7);
    check("sub_res", alu(o_alu_ctrl, o_alu_in1, o_alu_in2), 4);
    drive(BR, 3'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0);
    @(negedge clk);
    check("beq_ctrl", o_alu_ctrl, 4'b0110);
    check("beq_res", alu(o_alu_ctrl, o_alu_in1, o_alu_in2), 0);
    i_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", o_valid, 0);

    // Backpressure: three ADDIs, i_ready low
    i_ready = 1'b0;
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'd1);
    @(negedge clk);
    check("bp_ready1", o_ready, 1);
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'd2);
    @(negedge clk);
    check("bp_ready2", o_ready, 0);
    check("bp_hold1", o_alu_in2, 1);
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'd3);
    @(negedge clk);
    check("bp_ready3", o_ready, 0);
    check("bp_stable", o_alu_in2, 1);
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_out2", o_alu_in2, 2);
    check("bp_v2", o_valid, 1);
    @(negedge clk);
    check("bp_out3", o_alu_in2, 3);
    check("bp_v3", o_valid, 1);
    i_valid = 1'b0;
    @(negedge clk);
    check("bp_done", o_valid, 0);

    // Flush while in the skid state with a new input valid
    i_ready = 1'b0;
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'h11);
    @(negedge clk);
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'h22);
    @(negedge clk);
    check("fl_skid", o_ready, 0);
    drive(I, 3'd0, 1'b0, 32'd0, 32'd0, 32'h33);
    i_flush = 1'b1;
    @(negedge clk);
    check("fl_valid", o_valid, 0);
    check("fl_ready", o_ready, 1);
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    check("fl_empty", o_valid, 0);

    // Illegal encodings and a legal LW
    drive(R, 3'd4, 1'b0, 32'd5, 32'd6, 32'd0);
    @(negedge clk);
    check("ill_r_flag", o_illegal, 1);
    check("ill_r_ctrl", o_alu_ctrl, 4'b0010);
    check("ill_r_in1", o_alu_in1, 0);
    check("ill_r_in2", o_alu_in2, 0);
    drive(LD, 3'd0, 1'b0, 32'h100, 32'd0, 32'd4);
    @(negedge clk);
    check("ill_lw_flag", o_illegal, 1);
    drive(LD, 3'd2, 1'b0, 32'h100, 32'd0, 32'd4);
    @(negedge clk);
    check("lw_flag", o_illegal, 0);
    check("lw_res", alu(o_alu_ctrl, o_alu_in1, o_alu_in2), 32'h104);
    i_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset while in the skid state
    i_ready = 1'b0;
    drive(I, 3'd6, 1'b0, 32'hAA, 32'd0, 32'h55);
    @(negedge clk);
    drive(I, 3'd7, 1'b0, 32'hAA, 32'd0, 32'h0F);
    @(negedge clk);
    check("ar_skid", o_ready, 0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", o_valid, 0);
    check("ar_ready", o_ready, 1);
    check("ar_in1", o_alu_in1, 0);
    check("ar_in2", o_alu_in2, 0);
    check("ar_ctrl", o_alu_ctrl, 0);
    check("ar_illegal", o_illegal, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ar_post_ready", o_ready, 1);
    i_ready = 1'b1;
    drive(R, 3'd6, 1'b0, 32'hF0, 32'h0F, 32'd0);
    @(negedge clk);
    check("ar_or_ctrl", o_alu_ctrl, 4'b0001);
    check("ar_or_res", alu(o_alu_ctrl, o_alu_in1, o_alu_in2), 32'hFF);
    i_valid = 1'b0;
    @(negedge clk);

    // Mixed stream: i_ready toggling, then random, with occasional flush
    for (int c = 0; c < 300; c++) begin
      drive(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = (c < 150) ? c[0] : 1'($urandom_range(0, 1));
      i_flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
